// File: rtl/rv32_cache_refill.sv
// rv32 cache line refill controller.
// Critical-word-first wrapping fetch over a single-outstanding 32-bit bus.
module rv32_cache_refill #(
  parameter  int LINE_SIZE = 32,
  localparam int WORDS     = LINE_SIZE / 4,
  localparam int PTR_WIDTH = $clog2(LINE_SIZE / 4)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_req,
  input  logic [31:0]            miss_addr,
  output logic                   miss_ack,
  output logic                   fill_valid,
  output logic [31:0]            fill_addr,
  output logic [LINE_SIZE*8-1:0] fill_data,
  output logic                   fill_err,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [31:0]            mem_rdata,
  input  logic                   mem_rerr,
  output logic                   busy
);

  localparam int OFF = $clog2(LINE_SIZE);
  localparam logic [31:0] LMASK = ~(32'(LINE_SIZE) - 32'd1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t                 state;
  logic [31:0]            base;
  logic [PTR_WIDTH-1:0]   ptr;
  logic [PTR_WIDTH-1:0]   count;
  logic [LINE_SIZE*8-1:0] lbuf;
  logic                   err;

  logic [PTR_WIDTH-1:0]   nxt_ptr;
  logic [LINE_SIZE*8-1:0] lbuf_upd;

  assign nxt_ptr = ptr + 1'b1;

  always_comb begin
    lbuf_upd = lbuf;
    lbuf_upd[ptr*32 +: 32] = mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      ptr        <= '0;
      count      <= '0;
      lbuf       <= '0;
      err        <= 1'b0;
      miss_ack   <= 1'b0;
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      fill_data  <= '0;
      fill_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      busy       <= 1'b0;
    end else begin
      miss_ack   <= 1'b0;
      fill_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (miss_req) begin
            state    <= REQ;
            miss_ack <= 1'b1;
            busy     <= 1'b1;
            base     <= miss_addr & LMASK;
            ptr      <= miss_addr[OFF-1:2];
            count    <= '0;
            lbuf     <= '0;
            err      <= 1'b0;
            mem_req  <= 1'b1;
            mem_addr <= miss_addr & ~32'h3;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (mem_rerr) begin
              // unfetched slots keep the zeros cleared at accept
              err        <= 1'b1;
              state      <= DONE;
              fill_valid <= 1'b1;
              fill_addr  <= base;
              fill_data  <= lbuf;
              fill_err   <= 1'b1;
            end else begin
              lbuf  <= lbuf_upd;
              ptr   <= nxt_ptr;
              count <= count + 1'b1;
              if (&count) begin
                state      <= DONE;
                fill_valid <= 1'b1;
                fill_addr  <= base;
                fill_data  <= lbuf_upd;
                fill_err   <= err;
              end else begin
                state    <= REQ;
                mem_req  <= 1'b1;
                mem_addr <= {base[31:OFF], nxt_ptr, 2'b00};
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
